// File: rtl/chip8_display_scaler.sv
// rtl/chip8_display_scaler.sv - chip-8 64x32 VRAM line prefetcher and integer upscaler for a 1280x720 raster
module chip8_display_scaler #(
  parameter int          SCALE        = 16,
  parameter int          SCALE_LOG2   = 4,
  parameter int          X_OFF        = 128,
  parameter int          Y_OFF        = 104,
  parameter int          H_ACTIVE     = 1280,
  parameter int          H_TOTAL      = 1650,
  parameter int          V_TOTAL      = 750,
  parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  parameter logic [23:0] BORDER_COLOR = 24'h202020
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        active_draw_in,
  output logic        vram_req_out,
  output logic [7:0]  vram_addr_out,
  input  logic        vram_grant_in,
  input  logic        vram_valid_in,
  input  logic [7:0]  vram_data_in,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_draw_out,
  output logic        underrun_out
);

  localparam int          HBLANK = H_TOTAL - H_ACTIVE;
  localparam logic [10:0] H_TRIG = 11'(H_ACTIVE);
  localparam logic [10:0] X_LO   = 11'(X_OFF);
  localparam logic [10:0] X_HI   = 11'(X_OFF + 64 * SCALE);
  localparam logic [9:0]  Y_LO   = 10'(Y_OFF);
  localparam logic [9:0]  Y_HI   = 10'(Y_OFF + 32 * SCALE);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} fetch_state_t;

  fetch_state_t state_q, state_d;
  logic [4:0]   row_q;
  logic [2:0]   idx_q;
  logic         front_sel_q;
  logic [7:0]   line_buf [2][8];
  logic         start_fetch, store, swap, abort;

  logic [9:0]   next_v, nv_off, nv_sh;
  logic         nv_in_win;
  logic [10:0]  hx, hx_sh;
  logic [5:0]   col;
  logic         in_win;

  logic         act1, hs1, vs1, win1, bit1;
  logic [23:0]  pix_q;
  logic         unused_bits;

  assign next_v    = (vcount_in == V_LAST) ? 10'd0 : vcount_in + 10'd1;
  assign nv_in_win = (next_v >= Y_LO) && (next_v < Y_HI);
  assign nv_off    = next_v - Y_LO;
  assign nv_sh     = nv_off >> SCALE_LOG2;

  assign hx     = hcount_in - X_LO;
  assign hx_sh  = hx >> SCALE_LOG2;
  assign col    = hx_sh[5:0];
  assign in_win = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                  (vcount_in >= Y_LO) && (vcount_in < Y_HI);

  assign unused_bits = &{1'b0, nv_sh[9:5], hx_sh[10:6], HBLANK[0]};

  assign vram_req_out  = (state_q == S_REQ);
  assign vram_addr_out = {row_q, idx_q};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Line start wins over everything: a finished fetch is swapped in, an unfinished one is dropped.
  always_comb begin
    state_d     = state_q;
    start_fetch = 1'b0;
    store       = 1'b0;
    swap        = 1'b0;
    abort       = 1'b0;
    if (hcount_in == 11'd0) begin
      if (state_q == S_DONE) begin
        swap    = 1'b1;
        state_d = S_IDLE;
      end else if (state_q == S_REQ || state_q == S_WAIT) begin
        abort   = 1'b1;
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: if (hcount_in == H_TRIG && nv_in_win) begin
          start_fetch = 1'b1;
          state_d     = S_REQ;
        end
        S_REQ:  if (vram_grant_in) state_d = S_WAIT;
        S_WAIT: if (vram_valid_in) begin
          store   = 1'b1;
          state_d = (idx_q == 3'd7) ? S_DONE : S_REQ;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      row_q        <= 5'd0;
      idx_q        <= 3'd0;
      front_sel_q  <= 1'b0;
      underrun_out <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        line_buf[0][i] <= 8'd0;
        line_buf[1][i] <= 8'd0;
      end
    end else begin
      if (start_fetch) begin
        row_q <= nv_sh[4:0];
        idx_q <= 3'd0;
      end
      if (store) begin
        line_buf[~front_sel_q][idx_q] <= vram_data_in;
        if (idx_q != 3'd7) idx_q <= idx_q + 3'd1;
      end
      if (swap)  front_sel_q  <= ~front_sel_q;
      if (abort) underrun_out <= 1'b1;
    end
  end

  // Two-stage pixel pipe; syncs travel alongside so everything lags by exactly two clocks.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      act1            <= 1'b0;
      hs1             <= 1'b0;
      vs1             <= 1'b0;
      win1            <= 1'b0;
      bit1            <= 1'b0;
      pix_q           <= 24'd0;
      hsync_out       <= 1'b0;
      vsync_out       <= 1'b0;
      active_draw_out <= 1'b0;
    end else begin
      act1 <= active_draw_in;
      hs1  <= hsync_in;
      vs1  <= vsync_in;
      win1 <= in_win;
      bit1 <= line_buf[front_sel_q][col[5:3]][3'd7 - col[2:0]];
      if (!act1)      pix_q <= 24'd0;
      else if (!win1) pix_q <= BORDER_COLOR;
      else            pix_q <= bit1 ? FG_COLOR : BG_COLOR;
      hsync_out       <= hs1;
      vsync_out       <= vs1;
      active_draw_out <= act1;
    end
  end

  assign red_out   = pix_q[23:16];
  assign green_out = pix_q[15:8];
  assign blue_out  = pix_q[7:0];

endmodule

// File: tb/tb_chip8_display_scaler.sv
// tb/tb_chip8_display_scaler.sv - randomized bench for chip8_display_scaler against a frame-level model
module tb_chip8_display_scaler;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, active_draw_in;
  logic        vram_req_out;
  logic [7:0]  vram_addr_out;
  logic        vram_grant_in, vram_valid_in;
  logic [7:0]  vram_data_in;
  logic [7:0]  red_out, green_out, blue_out;
  logic        hsync_out, vsync_out, active_draw_out, underrun_out;

  chip8_display_scaler dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .active_draw_in(active_draw_in),
    .vram_req_out(vram_req_out), .vram_addr_out(vram_addr_out),
    .vram_grant_in(vram_grant_in), .vram_valid_in(vram_valid_in), .vram_data_in(vram_data_in),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .active_draw_out(active_draw_out),
    .underrun_out(underrun_out)
  );

  initial forever #5 clk_in = ~clk_in;

  logic [7:0]  vram [256];
  logic [7:0]  front [8];
  int          exp_addr_q[$];
  logic [31:0] exp_pix_q[$];
  logic        exp_underrun;
  bit          pending, pend_withheld;
  int          pend_row;
  bit          withhold, late_pulse;
  int          total = 0;
  int          bad = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_pix();
    return {5'b0, red_out, green_out, blue_out, hsync_out, vsync_out, active_draw_out};
  endfunction

  // VRAM arbiter/memory model: random grant delay, random read latency, one read in flight.
  initial begin
    int lat;
    int gdly;
    bit busy;
    logic [7:0] a;
    lat = 0; gdly = 0; busy = 0; a = 8'd0;
    vram_grant_in = 1'b0; vram_valid_in = 1'b0; vram_data_in = 8'd0;
    forever begin
      @(negedge clk_in);
      vram_grant_in = 1'b0;
      vram_valid_in = 1'b0;
      if (late_pulse) begin
        vram_valid_in = 1'b1;
        vram_data_in  = 8'hFF;
        late_pulse    = 1'b0;
      end else if (busy) begin
        lat--;
        if (lat == 0) begin
          vram_valid_in = 1'b1;
          vram_data_in  = vram[a];
          busy          = 1'b0;
        end
      end else if (vram_req_out && !withhold) begin
        if (gdly > 0) gdly--;
        else begin
          vram_grant_in = 1'b1;
          a = vram_addr_out;
          if (exp_addr_q.size() == 0) check("spurious_req", 32'(a), 32'hFFFF_FFFF);
          else check("addr", 32'(a), 32'(exp_addr_q.pop_front()));
          busy = 1'b1;
          lat  = int'($urandom_range(1, 4));
          gdly = int'($urandom_range(0, 3));
        end
      end
    end
  end

  task automatic step(int h, int v, logic ad);
    logic hs, vs;
    logic [23:0] rgb;
    logic [7:0] b;
    bit win;
    int col, nv;
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    hcount_in = 11'(h); vcount_in = 10'(v);
    hsync_in = hs; vsync_in = vs; active_draw_in = ad;
    win = (h >= 128) && (h < 128 + 64 * 16) && (v >= 104) && (v < 104 + 32 * 16);
    if (!ad) rgb = 24'h000000;
    else if (!win) rgb = 24'h202020;
    else begin
      col = (h - 128) / 16;
      b   = front[col / 8];
      rgb = b[3'(7 - col % 8)] ? 24'hFFFFFF : 24'h000000;
    end
    exp_pix_q.push_back({5'b0, rgb, hs, vs, ad});
    if (h == 0 && pending) begin
      pending = 0;
      if (pend_withheld) begin
        exp_underrun = 1'b1;
        exp_addr_q.delete();
      end else begin
        check("fetch_cnt", 32'(exp_addr_q.size()), 32'd0);
        for (int i = 0; i < 8; i++) front[i] = vram[8'(pend_row * 8 + i)];
      end
    end
    if (h == 1280) begin
      nv = (v == 749) ? 0 : v + 1;
      if (nv >= 104 && nv < 104 + 512) begin
        pending       = 1;
        pend_withheld = withhold;
        pend_row      = (nv - 104) / 16;
        for (int i = 0; i < 8; i++) exp_addr_q.push_back(pend_row * 8 + i);
      end
    end
    @(posedge clk_in); #1;
    if (exp_pix_q.size() == 2) check("pix", dut_pix(), exp_pix_q.pop_front());
    check("underrun", 32'(underrun_out), 32'(exp_underrun));
  endtask

  task automatic run_line(int v, bit rand_ad, bit wh, bit late, int h_from, int h_to);
    for (int h = h_from; h <= h_to; h++) begin
      if (h == 1) withhold = wh;
      if (h == 3 && late) late_pulse = 1'b1;
      step(h, v, rand_ad ? 1'($urandom_range(0, 1)) : logic'(h < 1280 && v < 720));
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_pix"}, dut_pix(), 32'd0);
    check({tag, "_req"}, 32'(vram_req_out), 32'd0);
    check({tag, "_addr"}, 32'(vram_addr_out), 32'd0);
    check({tag, "_underrun"}, 32'(underrun_out), 32'd0);
  endtask

  task automatic model_reset();
    exp_pix_q.delete();
    exp_pix_q.push_back(32'd0);
    exp_addr_q.delete();
    pending = 0;
    exp_underrun = 1'b0;
    for (int i = 0; i < 8; i++) front[i] = 8'd0;
  endtask

  initial begin
    rst_in = 1'b0;
    hcount_in = 11'd0; vcount_in = 10'd0;
    hsync_in = 1'b0; vsync_in = 1'b0; active_draw_in = 1'b0;
    withhold = 0; late_pulse = 0;
    for (int i = 0; i < 256; i++) vram[i] = 8'($urandom);
    vram[0] = 8'h80;
    #2 rst_in = 1'b1;
    #1 check_reset_outputs("por");
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    model_reset();

    run_line(102, 0, 0, 0, 0, 1649);
    for (int v = 103; v <= 105; v++) run_line(v, 0, 0, 0, 0, 1649);
    for (int v = 118; v <= 121; v++) run_line(v, 0, 0, 0, 0, 1649);
    run_line(134, 0, 0, 0, 0, 1649);
    run_line(135, 0, 1, 0, 0, 1649);
    run_line(136, 0, 0, 1, 0, 1649);
    run_line(137, 0, 0, 0, 0, 1649);
    run_line(299, 0, 0, 0, 0, 1649);
    run_line(300, 1, 0, 0, 0, 1649);
    run_line(399, 0, 0, 0, 0, 1649);

    run_line(400, 0, 0, 0, 0, 1283);
    #2 rst_in = 1'b1;
    #1 check_reset_outputs("midrst");
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    model_reset();
    run_line(400, 0, 0, 0, 1284, 1649);
    run_line(401, 0, 0, 0, 0, 1649);
    run_line(402, 0, 0, 0, 0, 1649);

    for (int v = 614; v <= 616; v++) run_line(v, 0, 0, 0, 0, 1649);
    run_line(749, 0, 0, 0, 0, 1649);
    run_line(0, 0, 0, 0, 0, 1649);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
